// File: rtl/sram_mem_controller_pkg.sv
// Shared definitions for the SRAM data-memory controller: FSM encoding, default base address, pad width.
package sram_mem_controller_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } sram_state_e;

    localparam int unsigned ADDR_BASE_DEFAULT = 32'd1024;
    localparam int          SRAM_DW           = 16;
endpackage

// File: rtl/sram_beat_timer.sv
// Per-beat wait-state counter: reloaded with WAIT_CYCLES on entry to a beat, flags the beat's last cycle.
module sram_beat_timer #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    output logic o_last
);
    logic [3:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= 4'd0;
        end else if (i_load) begin
            r_count <= 4'(WAIT_CYCLES);
        end else if (!o_last) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign o_last = (r_count == 4'd0);
endmodule

// File: rtl/sram_mem_controller.sv
// Maps 32-bit MEM-stage loads/stores onto a 16-bit async SRAM as two half-word beats.
// Optional SRAM_CTRL_STATS_EN adds saturating rd_count/wr_count outputs.
module sram_mem_controller
    import sram_mem_controller_pkg::*;
#(
    parameter int unsigned ADDR_BASE   = ADDR_BASE_DEFAULT,
    parameter int unsigned SRAM_AW     = 18,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_we_n,
    output logic               sram_oe_n,
    output logic               sram_ce_n,
    output sram_state_e        dbg_state
`ifdef SRAM_CTRL_STATS_EN
    ,
    output logic [15:0]        rd_count,
    output logic [15:0]        wr_count
`endif
);
    sram_state_e        r_state;
    logic [SRAM_AW-2:0] r_word;
    logic [31:0]        r_wdata;
    logic [31:0]        r_read_data;
    logic               r_is_wr;

    logic        w_req;
    logic        w_last;
    logic        w_busy;
    logic        w_load;
    logic [31:0] w_offset;
    logic        w_unused;

    assign w_req    = rd_en | wr_en;
    assign w_offset = address - ADDR_BASE;
    // Byte offset within the word and bits above the SRAM window are dropped.
    assign w_unused = ^{w_offset[31:SRAM_AW+1], w_offset[1:0]};
    assign w_busy   = (r_state == LO) || (r_state == HI);
    assign w_load   = ((r_state == IDLE) && w_req) || ((r_state == LO) && w_last);

    sram_beat_timer #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_beat_timer (
        .clk   (clk),
        .rst   (rst),
        .i_load(w_load),
        .o_last(w_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_word      <= '0;
            r_wdata     <= '0;
            r_is_wr     <= 1'b0;
            r_read_data <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_state <= LO;
                        r_word  <= w_offset[SRAM_AW:2];
                        r_wdata <= write_data;
                        r_is_wr <= wr_en;
                    end
                end
                LO: begin
                    if (w_last) begin
                        r_state <= HI;
                        if (!r_is_wr) r_read_data[15:0] <= sram_dq_in;
                    end
                end
                HI: begin
                    if (w_last) begin
                        r_state <= DONE;
                        if (!r_is_wr) r_read_data[31:16] <= sram_dq_in;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // we_n is released on each beat's last cycle so data is held past the strobe edge.
    assign sram_ce_n   = ~w_busy;
    assign sram_oe_n   = ~(w_busy & ~r_is_wr);
    assign sram_we_n   = ~(w_busy & r_is_wr & ~w_last);
    assign sram_dq_oe  = w_busy & r_is_wr;
    assign sram_addr   = {r_word, (r_state == HI)};
    assign sram_dq_out = (r_state == HI) ? r_wdata[31:16] : r_wdata[15:0];
    assign ready       = ~w_req | (r_state == DONE);
    assign read_data   = r_read_data;
    assign dbg_state   = r_state;

`ifdef SRAM_CTRL_STATS_EN
    logic [15:0] r_rd_count;
    logic [15:0] r_wr_count;
    logic        w_enter_done;

    assign w_enter_done = (r_state == HI) && w_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_count <= 16'd0;
            r_wr_count <= 16'd0;
        end else if (w_enter_done) begin
            if (r_is_wr) begin
                if (r_wr_count != 16'hFFFF) r_wr_count <= r_wr_count + 16'd1;
            end else begin
                if (r_rd_count != 16'hFFFF) r_rd_count <= r_rd_count + 16'd1;
            end
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`endif
endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: three instances (WAIT_CYCLES 1, 0, 3) against a half-word SRAM model.
module tb_sram_mem_controller;
    import sram_mem_controller_pkg::*;

    localparam int N = 3;

    logic        clk;
    logic        rst;
    logic        mem_init;
    logic        wr_en       [N];
    logic        rd_en       [N];
    logic [31:0] address     [N];
    logic [31:0] write_data  [N];
    logic [31:0] read_data   [N];
    logic        ready       [N];
    logic [17:0] sram_addr   [N];
    logic [15:0] dq_out      [N];
    logic [15:0] dq_in       [N];
    logic        dq_oe       [N];
    logic        we_n        [N];
    logic        oe_n        [N];
    logic        ce_n        [N];
    sram_state_e dbg_state   [N];
`ifdef SRAM_CTRL_STATS_EN
    logic [15:0] rd_count    [N];
    logic [15:0] wr_count    [N];
`endif

    function automatic int wait_of(input int k);
        case (k)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        sram_mem_controller #(
            .ADDR_BASE  (1024),
            .SRAM_AW    (18),
            .WAIT_CYCLES(wait_of(g))
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .wr_en      (wr_en[g]),
            .rd_en      (rd_en[g]),
            .address    (address[g]),
            .write_data (write_data[g]),
            .read_data  (read_data[g]),
            .ready      (ready[g]),
            .sram_addr  (sram_addr[g]),
            .sram_dq_out(dq_out[g]),
            .sram_dq_oe (dq_oe[g]),
            .sram_dq_in (dq_in[g]),
            .sram_we_n  (we_n[g]),
            .sram_oe_n  (oe_n[g]),
            .sram_ce_n  (ce_n[g]),
            .dbg_state  (dbg_state[g])
`ifdef SRAM_CTRL_STATS_EN
            ,
            .rd_count   (rd_count[g]),
            .wr_count   (wr_count[g])
`endif
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Half-word SRAM model: initial pattern, write while ce_n/we_n low and pad driven, read while oe_n low.
    logic [15:0] smem [N][512];

    function automatic logic [15:0] init_val(input int a);
        return 16'(a * 40503 + 23130);
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (mem_init) begin
                for (int i = 0; i < 512; i++) smem[k][i] <= init_val(i);
            end else if (!ce_n[k] && !we_n[k] && dq_oe[k]) begin
                smem[k][sram_addr[k][8:0]] <= dq_out[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < N; k++) begin
            dq_in[k] = (!oe_n[k] && !ce_n[k]) ? smem[k][sram_addr[k][8:0]] : 16'h0000;
        end
    end

    // Word-level reference: what a 32-bit load must return.
    logic [31:0] ref_mem [int];
    logic [31:0] last_rd [N];
    int          rd_exp  [N];
    int          wr_exp  [N];
    int          errors = 0;
    int          checks = 0;

    function automatic logic [31:0] ref_read(input int k, input int word);
        int key;
        key = k * 262144 + word;
        if (ref_mem.exists(key)) return ref_mem[key];
        return {init_val(2 * word + 1), init_val(2 * word)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_access(input int k, input logic wr, input logic rd, input logic [31:0] addr,
                             input logic [31:0] wd, output int lat, output int busy, output int we_low,
                             output logic oe_seen, output logic [17:0] a_lo, output logic [17:0] a_hi,
                             output logic [15:0] d_lo, output logic [15:0] d_hi, output logic [31:0] rdata);
        bit first;
        wr_en[k] = wr;
        rd_en[k] = rd;
        address[k] = addr;
        write_data[k] = wd;
        lat = -1; busy = 0; we_low = 0; oe_seen = 1'b0; first = 1'b1;
        a_lo = '0; a_hi = '0; d_lo = '0; d_hi = '0; rdata = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!ce_n[k]) begin
                busy++;
                if (first) begin
                    a_lo = sram_addr[k];
                    d_lo = dq_out[k];
                    first = 1'b0;
                end
                a_hi = sram_addr[k];
                d_hi = dq_out[k];
                if (!we_n[k]) we_low++;
                if (!oe_n[k]) oe_seen = 1'b1;
            end
            if (ready[k]) begin
                lat = c;
                rdata = read_data[k];
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        wr_en[k] = 1'b0;
        rd_en[k] = 1'b0;
    endtask

    task automatic verify(input int k, input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input string tag);
        int          lat, busy, we_low, w;
        logic        oe_seen;
        logic [17:0] a_lo, a_hi, exp_lo;
        logic [15:0] d_lo, d_hi;
        logic [31:0] rdata;
        w = wait_of(k);
        exp_lo = 18'(((addr - 32'd1024) >> 2) << 1);
        do_access(k, wr, rd, addr, wd, lat, busy, we_low, oe_seen, a_lo, a_hi, d_lo, d_hi, rdata);
        check({tag, "_latency"}, lat, 2 * (w + 1) + 1);
        check({tag, "_busy_cycles"}, busy, 2 * (w + 1));
        check({tag, "_addr_lo"}, a_lo, exp_lo);
        check({tag, "_addr_hi"}, a_hi, exp_lo | 18'd1);
        if (lat >= 0) begin
            if (wr) wr_exp[k]++;
            else rd_exp[k]++;
        end
        if (wr) begin
            check({tag, "_dq_lo"}, d_lo, wd[15:0]);
            check({tag, "_dq_hi"}, d_hi, wd[31:16]);
            check({tag, "_we_low"}, we_low, 2 * w);
            check({tag, "_oe_idle"}, oe_seen, 1'b0);
            check({tag, "_rdata_hold"}, rdata, last_rd[k]);
            if (w > 0) ref_mem[k * 262144 + int'(exp_lo >> 1)] = wd;
        end else begin
            check({tag, "_rdata"}, rdata, exp_rd);
            check({tag, "_we_idle"}, we_low, 0);
            check({tag, "_oe_seen"}, oe_seen, 1'b1);
            last_rd[k] = exp_rd;
        end
    endtask

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t        vecs [9];
    int          kk;
    int          word;
    logic        rwr;
    logic        rrd;
    logic [31:0] raddr;
    logic [31:0] rwd;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        mem_init = 1'b1;
        for (int k = 0; k < N; k++) begin
            wr_en[k] = 1'b0; rd_en[k] = 1'b0; address[k] = '0; write_data[k] = '0;
            last_rd[k] = '0; rd_exp[k] = 0; wr_exp[k] = 0;
        end
        repeat (3) @(negedge clk);

        check("rst_ready", ready[0], 1'b1);
        check("rst_we_n", we_n[0], 1'b1);
        check("rst_oe_n", oe_n[0], 1'b1);
        check("rst_ce_n", ce_n[0], 1'b1);
        check("rst_dq_oe", dq_oe[0], 1'b0);
        check("rst_addr", sram_addr[0], 18'd0);
        check("rst_dq_out", dq_out[0], 16'd0);
        check("rst_read_data", read_data[0], 32'd0);
        check("rst_state", dbg_state[0], IDLE);

        mem_init = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;

        vecs[0] = '{1'b1, 1'b0, 32'd1024,          32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 32'd1024,          32'h0,        32'hDEADBEEF};
        vecs[2] = '{1'b0, 1'b1, 32'd1024 + 23,     32'h0,        {init_val(11), init_val(10)}};
        vecs[3] = '{1'b1, 1'b1, 32'd1032,          32'h12345678, 32'h0};
        vecs[4] = '{1'b0, 1'b1, 32'd1032,          32'h0,        32'h12345678};
        vecs[5] = '{1'b0, 1'b1, 32'd1027,          32'h0,        32'hDEADBEEF};
        vecs[6] = '{1'b1, 1'b0, 32'd1024 + 800,    32'hA5A55A5A, 32'h0};
        vecs[7] = '{1'b0, 1'b1, 32'd1024 + 800,    32'h0,        32'hA5A55A5A};
        vecs[8] = '{1'b1, 1'b0, 32'd1020,          32'h0BADF00D, 32'h0};
        for (int i = 0; i < 9; i++) begin
            verify(0, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wd, vecs[i].exp_rd, $sformatf("vec%0d", i));
        end

        verify(1, 1'b1, 1'b0, 32'd1024 + 12, 32'hCAFEF00D, 32'h0, "w0_write");
        verify(1, 1'b0, 1'b1, 32'd1024 + 12, 32'h0, ref_read(1, 3), "w0_read");
        verify(2, 1'b1, 1'b0, 32'd1024 + 12, 32'h13572468, 32'h0, "w3_write");
        verify(2, 1'b0, 1'b1, 32'd1024 + 12, 32'h0, 32'h13572468, "w3_read");

        // Reset arrives while the first beat of a read is on the bus.
        @(posedge clk); #1;
        rd_en[0] = 1'b1;
        address[0] = 32'd1032;
        @(posedge clk); #1;
        check("midrst_in_beat", ce_n[0], 1'b0);
        #2 rst = 1'b0;
        #1;
        check("midrst_ce_n", ce_n[0], 1'b1);
        check("midrst_oe_n", oe_n[0], 1'b1);
        check("midrst_we_n", we_n[0], 1'b1);
        check("midrst_dq_oe", dq_oe[0], 1'b0);
        check("midrst_addr", sram_addr[0], 18'd0);
        check("midrst_read_data", read_data[0], 32'd0);
        check("midrst_ready_req", ready[0], 1'b0);
        rd_en[0] = 1'b0;
        #1;
        check("midrst_ready_idle", ready[0], 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_state", dbg_state[0], IDLE);
        check("midrst_ce_after", ce_n[0], 1'b1);
        for (int k = 0; k < N; k++) begin
            last_rd[k] = '0; rd_exp[k] = 0; wr_exp[k] = 0;
        end

        // Request withdrawn after the access has started: the read still completes.
        rd_en[0] = 1'b1;
        address[0] = 32'd1024;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rd_en[0] = 1'b0;
        #1;
        check("withdraw_ready", ready[0], 1'b1);
        repeat (6) @(posedge clk);
        #1;
        check("withdraw_rdata", read_data[0], ref_read(0, 0));
        check("withdraw_state", dbg_state[0], IDLE);
        last_rd[0] = ref_read(0, 0);
        rd_exp[0]++;

        for (int i = 0; i < 40; i++) begin
            kk = (i % 2 == 0) ? 0 : 2;
            word = int'($urandom_range(0, 200));
            rwr = 1'($urandom_range(0, 1));
            rrd = rwr ? 1'($urandom_range(0, 1)) : 1'b1;
            raddr = 32'd1024 + 32'(word * 4) + $urandom_range(0, 3);
            rwd = $urandom;
            verify(kk, rwr, rrd, raddr, rwd, ref_read(kk, word), $sformatf("rnd%0d", i));
        end

`ifdef SRAM_CTRL_STATS_EN
        for (int k = 0; k < N; k++) begin
            check($sformatf("stats_rd%0d", k), rd_count[k], rd_exp[k]);
            check($sformatf("stats_wr%0d", k), wr_count[k], wr_exp[k]);
        end
        force g_dut[0].u_dut.r_rd_count = 16'hFFFF;
        force g_dut[0].u_dut.r_wr_count = 16'hFFFF;
        @(posedge clk); #1;
        release g_dut[0].u_dut.r_rd_count;
        release g_dut[0].u_dut.r_wr_count;
        verify(0, 1'b0, 1'b1, 32'd1024, 32'h0, ref_read(0, 0), "sat_read");
        verify(0, 1'b1, 1'b0, 32'd1028, 32'h55AA55AA, 32'h0, "sat_write");
        check("stats_rd_sat", rd_count[0], 16'hFFFF);
        check("stats_wr_sat", wr_count[0], 16'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
